// File: rtl/writeback_regfile_if.sv
// Writeback/regfile bus: MEM/WB writeback inputs, decode read ports,
// debug read port and status outputs. slave = regfile, master = driver.
interface writeback_regfile_if;
  logic        RegWriteW;
  logic        MemtoRegW;
  logic [31:0] ReadDataW;
  logic [31:0] ALUOutW;
  logic [4:0]  WriteRegW;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic [31:0] ResultW;
  logic [4:0]  DbgAddr;
  logic [31:0] DbgData;
  logic [31:0] WbCount;
  logic        ZeroWriteErr;

  modport slave (
    input  RegWriteW, MemtoRegW, ReadDataW, ALUOutW,
    input  WriteRegW, A1, A2, DbgAddr,
    output RD1, RD2, ResultW, DbgData,
    output WbCount, ZeroWriteErr
  );

  modport master (
    output RegWriteW, MemtoRegW, ReadDataW, ALUOutW,
    output WriteRegW, A1, A2, DbgAddr,
    input  RD1, RD2, ResultW, DbgData,
    input  WbCount, ZeroWriteErr
  );
endinterface

// File: rtl/writeback_regfile.sv
// Writeback result mux + 31x32 register file with write-before-read
// bypass, debug read port, commit counter and sticky r0-write flag.
// Ports: CLK, RST_N (async active-low), wb (writeback_regfile_if.slave).
module writeback_regfile (
  input  logic               CLK,
  input  logic               RST_N,
  writeback_regfile_if.slave wb
);

  logic [31:0] rf [1:31];
  logic [31:0] result;
  logic        commit;
  logic        zero_wr;
  logic [31:0] cnt_q;
  logic        zerr_q;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] dbg;

  assign result  = wb.MemtoRegW ? wb.ReadDataW : wb.ALUOutW;
  assign commit  = wb.RegWriteW && (wb.WriteRegW != 5'd0);
  assign zero_wr = wb.RegWriteW && (wb.WriteRegW == 5'd0);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 1; i < 32; i++) begin
        rf[i] <= '0;
      end
    end else if (commit) begin
      rf[wb.WriteRegW] <= result;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q  <= '0;
      zerr_q <= 1'b0;
    end else begin
      if (commit) begin
        cnt_q <= cnt_q + 32'd1;
      end
      if (zero_wr) begin
        zerr_q <= 1'b1;
      end
    end
  end

  // Bypass is not gated by reset: the forwarding path stays live.
  always_comb begin
    rd1 = '0;
    unique case (1'b1)
      (wb.A1 == 5'd0):
        rd1 = '0;
      (commit && (wb.A1 == wb.WriteRegW)):
        rd1 = result;
      default:
        rd1 = rf[wb.A1];
    endcase
  end

  always_comb begin
    rd2 = '0;
    unique case (1'b1)
      (wb.A2 == 5'd0):
        rd2 = '0;
      (commit && (wb.A2 == wb.WriteRegW)):
        rd2 = result;
      default:
        rd2 = rf[wb.A2];
    endcase
  end

  always_comb begin
    dbg = '0;
    if (wb.DbgAddr != 5'd0) begin
      dbg = rf[wb.DbgAddr];
    end
  end

  assign wb.ResultW      = result;
  assign wb.RD1          = rd1;
  assign wb.RD2          = rd2;
  assign wb.DbgData      = dbg;
  assign wb.WbCount      = cnt_q;
  assign wb.ZeroWriteErr = zerr_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile: directed cases
// then randomized traffic against an array-based reference model.
module tb_writeback_regfile;

  logic CLK;
  logic RST_N;
  int   checks;
  int   errors;

  logic [31:0] mdl [32];
  logic [31:0] mcnt;
  logic        mzerr;

  writeback_regfile_if w();

  writeback_regfile dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .wb    (w.slave)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(bit we, bit m2r, logic [31:0] rdat,
                       logic [31:0] alu, logic [4:0] wr,
                       logic [4:0] a1, logic [4:0] a2,
                       logic [4:0] da);
    w.RegWriteW = we;
    w.MemtoRegW = m2r;
    w.ReadDataW = rdat;
    w.ALUOutW   = alu;
    w.WriteRegW = wr;
    w.A1        = a1;
    w.A2        = a2;
    w.DbgAddr   = da;
  endtask

  function automatic logic [31:0] exp_res();
    return w.MemtoRegW ? w.ReadDataW : w.ALUOutW;
  endfunction

  // Architectural view: r0 is zero; a pending write is visible
  // to decode reads in the same cycle.
  function automatic logic [31:0] exp_rd(logic [4:0] a);
    if (a == 0) return 32'd0;
    if (w.RegWriteW && w.WriteRegW == a) return exp_res();
    return mdl[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    mcnt  = 32'd0;
    mzerr = 1'b0;
  endtask

  task automatic check_comb(string tag);
    #1;
    chk({tag, ".res"}, w.ResultW, exp_res());
    chk({tag, ".rd1"}, w.RD1, exp_rd(w.A1));
    chk({tag, ".rd2"}, w.RD2, exp_rd(w.A2));
    chk({tag, ".dbg"}, w.DbgData, mdl[w.DbgAddr]);
  endtask

  task automatic step(string tag);
    @(posedge CLK);
    if (RST_N && w.RegWriteW) begin
      if (w.WriteRegW == 0) begin
        mzerr = 1'b1;
      end else begin
        mdl[w.WriteRegW] = exp_res();
        mcnt = mcnt + 32'd1;
      end
    end
    #1;
    chk({tag, ".dbg_post"}, w.DbgData, mdl[w.DbgAddr]);
    chk({tag, ".cnt"}, w.WbCount, mcnt);
    chk({tag, ".zerr"}, {31'd0, w.ZeroWriteErr}, {31'd0, mzerr});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_reset();
    RST_N = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst.cnt", w.WbCount, 32'd0);
    chk("rst.zerr", {31'd0, w.ZeroWriteErr}, 32'd0);
    chk("rst.rd1", w.RD1, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;

    drive(1, 0, 32'h0, 32'h0000_1234, 5, 5, 0, 5);
    check_comb("bypass5");
    chk("bypass5.rd1c", w.RD1, 32'h1234);
    chk("bypass5.nodbg", w.DbgData, 32'd0);
    step("bypass5");
    chk("bypass5.dbgc", w.DbgData, 32'h1234);
    chk("bypass5.cntc", w.WbCount, 32'd1);

    drive(1, 1, 32'hDEAD_BEEF, 32'h1, 31, 0, 0, 31);
    check_comb("load31");
    chk("load31.resc", w.ResultW, 32'hDEAD_BEEF);
    step("load31");
    chk("load31.dbgc", w.DbgData, 32'hDEAD_BEEF);

    drive(1, 0, 32'h0, 32'hFFFF_FFFF, 0, 0, 0, 0);
    check_comb("r0wr");
    step("r0wr");
    chk("r0wr.zerrc", {31'd0, w.ZeroWriteErr}, 32'd1);
    chk("r0wr.cntc", w.WbCount, 32'd2);

    drive(1, 0, 32'h0, 32'hA, 7, 0, 0, 7);
    check_comb("r7a");
    step("r7a");
    drive(0, 0, 32'h0, 32'h0, 0, 7, 7, 7);
    check_comb("r7rd");
    chk("r7rd.rd2c", w.RD2, 32'hA);
    drive(1, 0, 32'h0, 32'hB, 7, 7, 7, 7);
    check_comb("r7b");
    chk("r7b.rd1c", w.RD1, 32'hB);
    chk("r7b.dbgold", w.DbgData, 32'hA);
    step("r7b");

    drive(0, 0, 32'h0, 32'h55, 3, 3, 3, 3);
    check_comb("nowe3");
    step("nowe3");
    chk("nowe3.dbgc", w.DbgData, 32'd0);

    // asynchronous reset mid-cycle
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    RST_N = 1'b0;
    model_reset();
    #1;
    chk("arst.cnt", w.WbCount, 32'd0);
    chk("arst.zerr", {31'd0, w.ZeroWriteErr}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      w.A1 = i[4:0];
      w.DbgAddr = i[4:0];
      #1;
      chk("arst.rd1", w.RD1, 32'd0);
      chk("arst.dbg", w.DbgData, 32'd0);
    end

    drive(1, 0, 32'h0, 32'h77, 9, 9, 0, 9);
    check_comb("rstwr");
    step("rstwr");
    chk("rstwr.lost", w.DbgData, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    drive(1, 0, 32'h0, 32'h99, 9, 0, 9, 9);
    check_comb("resume");
    step("resume");
    chk("resume.dbgc", w.DbgData, 32'h99);

    for (int n = 0; n < 400; n++) begin
      logic [4:0] wr;
      wr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3))
                                       : 5'($urandom);
      drive($urandom_range(0, 3) != 0, 1'($urandom), $urandom,
            $urandom, wr,
            ($urandom_range(0, 2) == 0) ? wr : 5'($urandom),
            ($urandom_range(0, 2) == 0) ? wr : 5'($urandom),
            5'($urandom));
      check_comb("rnd");
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
